// File: rtl/tpiu_frame_demux.sv
// CoreSight TPIU formatter decoder: turns synchronised 16-byte frames into an
// ID-tagged byte stream with a valid/ready handshake and two-deep frame buffering.
module tpiu_frame_demux #(
    parameter int SYNC_STAGES = 2,
    parameter bit DROP_NULL   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PkAvail,
    input  logic [127:0] Packet,
    output logic         DataVal,
    input  logic         DataReady,
    output logic [7:0]   DataByte,
    output logic [6:0]   DataStream,
    output logic [7:0]   OverflowCnt,
    output logic         Busy
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, DECODE, OUT} state_t;

    state_t         state;
    logic [SS-1:0]  sync;
    logic           sync_q;
    logic           frame_edge;
    logic [127:0]   work;
    logic [127:0]   hold;
    logic           hold_full;
    logic [3:0]     ptr;
    logic [6:0]     cur_id;
    logic [6:0]     pend_id;
    logic           pend_vld;

    logic [7:0]     slot;
    logic [7:0]     aux;
    logic           aux_bit;
    logic           is_id;
    logic           drop;
    logic           last;
    logic           done;
    logic           work_free;
    logic [7:0]     data;

    assign frame_edge = sync[SS-1] & ~sync_q;

    assign slot    = work[{ptr, 3'b000} +: 8];
    assign aux     = work[127:120];
    assign aux_bit = aux[ptr[3:1]];
    assign is_id   = ~ptr[0] & slot[0];
    assign data    = ptr[0] ? slot : {slot[7:1], aux_bit};
    assign drop    = DROP_NULL && ((cur_id == 7'h00) || (cur_id == 7'h7F));
    assign last    = (ptr == 4'd14);

    // Slot 14 finishing frees the work register in the same cycle so hold can refill it.
    assign done      = ((state == DECODE) && (is_id || drop) && last)
                     || ((state == OUT) && DataReady && last);
    assign work_free = (state == IDLE) || done;

    assign Busy = (state != IDLE) || hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sync        <= '0;
            sync_q      <= 1'b0;
            work        <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            ptr         <= 4'd0;
            cur_id      <= 7'h00;
            pend_id     <= 7'h00;
            pend_vld    <= 1'b0;
            DataVal     <= 1'b0;
            DataByte    <= 8'h00;
            DataStream  <= 7'h00;
            OverflowCnt <= 8'h00;
        end else begin
            sync   <= {sync[SS-2:0], PkAvail};
            sync_q <= sync[SS-1];

            case (state)
                DECODE: begin
                    if (is_id) begin
                        // A delayed change waits for the odd slot that follows it.
                        if (aux_bit && !last) begin
                            pend_vld <= 1'b1;
                            pend_id  <= slot[7:1];
                        end else begin
                            cur_id <= slot[7:1];
                        end
                        ptr <= ptr + 4'd1;
                    end else if (drop) begin
                        if (pend_vld) begin
                            cur_id   <= pend_id;
                            pend_vld <= 1'b0;
                        end
                        ptr <= ptr + 4'd1;
                    end else begin
                        DataVal    <= 1'b1;
                        DataByte   <= data;
                        DataStream <= cur_id;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (DataReady) begin
                        DataVal <= 1'b0;
                        if (pend_vld) begin
                            cur_id   <= pend_id;
                            pend_vld <= 1'b0;
                        end
                        ptr   <= ptr + 4'd1;
                        state <= DECODE;
                    end
                end
                default: ;
            endcase

            // Frame movement overrides the walk when the work register frees up.
            if (work_free) begin
                if (hold_full) begin
                    work  <= hold;
                    ptr   <= 4'd0;
                    state <= DECODE;
                    if (frame_edge) hold <= Packet;
                    else            hold_full <= 1'b0;
                end else if (frame_edge) begin
                    work  <= Packet;
                    ptr   <= 4'd0;
                    state <= DECODE;
                end else if (done) begin
                    state <= IDLE;
                end
            end else if (frame_edge) begin
                if (hold_full) begin
                    if (OverflowCnt != 8'hFF) OverflowCnt <= OverflowCnt + 8'd1;
                end else begin
                    hold      <= Packet;
                    hold_full <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/tpiu_frame_demux.md
Name: tpiu_frame_demux

Overview:
- Downstream consumer of traceIF: takes the 128-bit synchronised TPIU frames it produces (Packet/PkAvail) and decodes the CoreSight formatter protocol.
- Output is a byte stream tagged with a 7-bit trace source ID, using a valid/ready handshake, for the packet processors (ITM/ETM decoders, USB/host FIFO).
- Handles immediate and delayed ID changes, aux-byte LSB restoration, null-ID suppression, and frame overflow accounting.

Parameters:
- SYNC_STAGES, 2: flops in PkAvail synchroniser (min 2).
- DROP_NULL, 1: 1 = bytes carrying ID 0x00 or 0x7F are discarded, not emitted.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- PkAvail  in  1  frame-available level from traceIF (traceClkin domain); a rising edge marks a new frame
- Packet  in  128  frame; byte k = Packet[8k+7:8k]; stable while PkAvail is high
- DataVal  out  1  output byte valid
- DataReady  in  1  downstream accepts DataByte
- DataByte  out  8  decoded data byte
- DataStream  out  7  source ID of DataByte
- OverflowCnt  out  8  frames dropped, saturating at 0xFF
- Busy  out  1  a frame is being decoded or is held pending

Behaviour:
- Reset (rst low, async): DataVal=0, DataByte=0, DataStream=0, OverflowCnt=0, Busy=0; current ID=0; pending-ID cleared; both frame registers empty; synchroniser cleared.
- Frame capture:
  - PkAvail passes through SYNC_STAGES flops; a rising edge of the synchronised signal copies Packet into the hold register.
  - Hold register moves to the work register whenever the work register is empty.
  - 2 frames deep in total (work + hold).
  - If a new edge arrives while hold is full, the new frame is dropped and OverflowCnt increments (saturating). Hold is not overwritten.
- Frame decode:
  - aux = byte 15; aux bit k belongs to slot 2k, k=0..7.
  - Slots 0..14 are walked in order, at most one slot per cycle.
  - Even slot, bit0=1: ID change, newID = byte[7:1]. No output; consumes 1 cycle.
    - aux bit = 0: current ID = newID immediately.
    - aux bit = 1: newID becomes pending; it applies after slot 2k+1 is processed.
    - Slot 14 has no following byte, so it always applies immediately.
  - Even slot, bit0=0: data = {byte[7:1], aux bit k}.
  - Odd slot: data = byte as is.
  - Data while current ID is 0x00 or 0x7F with DROP_NULL=1: discarded, 1 cycle, no output.
- States:
  - IDLE: work register empty, DataVal=0. Goes to DECODE when the work register is loaded.
  - DECODE: evaluates the slot at the pointer. An emitting slot goes to OUT; otherwise pointer+1.
  - OUT: DataVal=1. DataByte/DataStream are held stable until DataVal&&DataReady.
    - On acceptance: apply any pending ID, pointer+1, back to DECODE.
    - When slot 14 completes, the work register is emptied and the FSM goes to IDLE, or reloads immediately from hold (same cycle).
- Handshake:
  - DataVal never drops without acceptance.
  - DataReady may be high before DataVal.
  - Throughput is at most 1 byte per 2 clk.
- Latency: with the block idle, frame slot 0 being data and a non-null ID, DataVal is high exactly SYNC_STAGES+2 clk edges after the first clk edge that samples PkAvail high.
- Current ID persists across frames; it is cleared only by reset.
- Busy = work register occupied || hold register occupied.
- PkAvail held high produces only one frame; it must fall before the next frame is seen.

Test Plan:
- Reset: drive rst low mid-frame with DataVal=1 -> all outputs 0 immediately. After release, the next frame decodes from slot 0 with ID 0, and bytes are suppressed until an ID change.
- Immediate ID: byte0=0x03, aux=0x02, byte1=0x12, byte2=0x44, bytes 3..14=0x00 -> emits 0x12, 0x45, then twelve 0x00, all with DataStream=0x01.
- Delayed ID: ID 1 active; byte4=0x05, aux bit2=1, byte5=0xAA, byte6=0x10 -> 0xAA on stream 1, then 0x10 on stream 2.
- Backpressure: hold DataReady low for 10 cycles mid-frame -> DataVal stays 1; DataByte and DataStream are unchanged; no byte lost or duplicated; all 15-slot outputs are in order.
- Overflow: DataReady low; send 3 frames with PkAvail pulses 20 clk apart -> OverflowCnt=1, Busy=1. After releasing DataReady, exactly frames 1 and 2 are emitted and Busy then returns to 0.
- Null filter: ID set to 0x00 via byte0=0x01 -> no DataVal for that frame's data. Same frame with DROP_NULL=0 -> the bytes are emitted with DataStream=0x00.
